// File: rtl/jk_pkg.sv
// Shared JK mode encoding used by the flip-flop cells and by anything that
// needs to reason about J/K pairs symbolically.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_t;

    function automatic jk_mode_t jk_mode(input logic j, input logic k);
        return jk_mode_t'({j, k});
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset to a
// per-cell reset value.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q
);

    logic     q_r;
    logic     q_next_s;
    jk_mode_t mode_s;

    // Next-state decode; unknown J/K falls to default and propagates X.
    always_comb begin
        mode_s   = jk_mode(j, k);
        q_next_s = q_r;
        case (mode_s)
            JK_HOLD: q_next_s = q_r;
            JK_CLR:  q_next_s = 1'b0;
            JK_SET:  q_next_s = 1'b1;
            JK_TGL:  q_next_s = ~q_r;
            default: q_next_s = 1'bx;
        endcase
    end

    // State register; reset overrides any pending JK action.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= rst_val;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK flip-flops; Qbar is derived from Q so the
// two outputs can never disagree.
module jk_flip_flop
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH-1:0] q_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RESET_VAL[i]),
            .j       (J[i]),
            .k       (K[i]),
            .q       (q_s[i])
        );
    end

    assign Q    = q_s;
    assign Qbar = ~q_s;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench: three bank configurations driven with directed and
// random J/K/rst, compared against a behavioural model built on jk_pkg.
module tb_jk_flip_flop;
    import jk_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, rst4;
    logic [0:0] j1, k1, j2, k2, q1, qb1, q2, qb2;
    logic [3:0] j4, k4, q4, qb4;

    int checks = 0;
    int errors = 0;

    logic       m1, m2;
    logic [3:0] m4;

    jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) u1 (
        .Q(q1), .Qbar(qb1), .J(j1), .K(k1), .clk(clk), .rst(rst1));
    jk_flip_flop #(.WIDTH(1), .RESET_VAL(1'b1)) u2 (
        .Q(q2), .Qbar(qb2), .J(j2), .K(k2), .clk(clk), .rst(rst2));
    jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) u4 (
        .Q(q4), .Qbar(qb4), .J(j4), .K(k4), .clk(clk), .rst(rst4));

    // Reference: what one bit becomes at an edge, by table lookup on the mode.
    function automatic logic ref_bit(logic q, logic j, logic k, logic r, logic rv);
        logic [3:0] table_v;
        jk_mode_t   md;
        if (r) return rv;
        md = jk_mode(j, k);
        table_v = {~q, 1'b1, 1'b0, q};   // index = mode: HOLD, CLR, SET, TGL
        case (md)
            JK_HOLD: return table_v[0];
            JK_CLR:  return table_v[1];
            JK_SET:  return table_v[2];
            JK_TGL:  return table_v[3];
            default: return 1'bx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare every bank.
    task automatic tick();
        @(posedge clk);
        m1 = ref_bit(m1, j1[0], k1[0], rst1, 1'b0);
        m2 = ref_bit(m2, j2[0], k2[0], rst2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] rv;
            rv = 4'b1010;
            m4[i] = ref_bit(m4[i], j4[i], k4[i], rst4, rv[i]);
        end
        #1;
        if (!$isunknown(m1)) begin
            chk("u1_q",    {3'b000, q1},  {3'b000, m1});
            chk("u1_qbar", {3'b000, qb1}, {3'b000, ~m1});
        end else begin
            chk("u1_qbar_inv", {3'b000, qb1}, {3'b000, ~q1});
        end
        if (!$isunknown(m2)) begin
            chk("u2_q",    {3'b000, q2},  {3'b000, m2});
            chk("u2_qbar", {3'b000, qb2}, {3'b000, ~m2});
        end
        if (!$isunknown(m4)) begin
            chk("u4_q",    q4,  m4);
            chk("u4_qbar", qb4, ~m4);
        end
    endtask

    initial begin
        m1 = 1'bx; m2 = 1'bx; m4 = 4'bxxxx;
        // Power-up hold on u1 (no reset); u2/u4 reset with toggle requested.
        rst1 = 1'b0; j1 = 1'b0; k1 = 1'b0;
        rst2 = 1'b1; j2 = 1'b1; k2 = 1'b1;
        rst4 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
        @(negedge clk);
        tick();
        chk("u2_reset_val", {3'b000, q2}, 4'b0001);
        chk("u4_reset_val", q4, 4'b1010);

        // u1 set resolves unknown; u2 toggles off reset; u4 holds.
        j1 = 1'b1; k1 = 1'b0;
        rst2 = 1'b0; j2 = 1'b1; k2 = 1'b1;
        rst4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
        tick();
        chk("u1_powerup_set", {3'b000, q1}, 4'b0001);
        chk("u2_first_tgl",   {3'b000, q2}, 4'b0000);

        // Reset beats toggle on u1; mid-toggle reset on u2; mixed modes on u4.
        rst1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
        rst2 = 1'b1;
        j4 = 4'b0011; k4 = 4'b0101;
        tick();
        chk("u1_rst_over_tgl", {3'b000, q1}, 4'b0000);
        chk("u1_rst_qbar",     {3'b000, qb1}, 4'b0001);
        chk("u2_mid_tgl_rst",  {3'b000, q2}, 4'b0001);
        chk("u4_mixed_q",      q4,  4'b1011);
        chk("u4_mixed_qbar",   qb4, 4'b0100);

        // Mode sweep on u1; u2 resumes toggling from its reset value.
        rst1 = 1'b0; rst2 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;
        j1 = 1'b0; k1 = 1'b0; tick(); chk("sweep_hold", {3'b000, q1}, 4'b0000);
        chk("u2_resume_tgl", {3'b000, q2}, 4'b0000);
        j1 = 1'b0; k1 = 1'b1; tick(); chk("sweep_clr",  {3'b000, q1}, 4'b0000);
        j1 = 1'b1; k1 = 1'b0; tick(); chk("sweep_set",  {3'b000, q1}, 4'b0001);
        j1 = 1'b1; k1 = 1'b1; tick(); chk("sweep_tgl",  {3'b000, q1}, 4'b0000);

        // Continuous toggle from 0: 1,0,1,0,1,0.
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("cont_tgl", {3'b000, q1}, (n % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // Randomized traffic on all banks, occasional reset.
        for (int n = 0; n < 300; n++) begin
            rst1 = ($urandom_range(15) == 0);
            rst2 = ($urandom_range(15) == 0);
            rst4 = ($urandom_range(15) == 0);
            j1 = 1'($urandom); k1 = 1'($urandom);
            j2 = 1'($urandom); k2 = 1'($urandom);
            j4 = 4'($urandom); k4 = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
